// File: rtl/ex_mem_sub2_pkg.sv
// Shared pipeline defines for the second-slot EX/MEM register: bus widths, reset/write polarities,
// exception bit positions, payload record types and the accumulate-count clamp.
package ex_mem_sub2_pkg;

    localparam int StallBus     = 6;
    localparam int RegBus       = 32;
    localparam int RegAddrBus   = 5;
    localparam int DoubleRegBus = 64;

    localparam logic RstEnable    = 1'b1;
    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;

    localparam logic [RegBus-1:0] ZeroWord = '0;

    // excepttype bit flagging arithmetic overflow; the write suppression lives upstream
    localparam int ExcOverflowBit = 12;

    localparam logic [1:0] CntMax = 2'b10;

    typedef struct packed {
        logic [RegAddrBus-1:0] wd;
        logic                  wreg;
        logic [RegBus-1:0]     wdata;
        logic [RegBus-1:0]     excepttype;
        logic [RegBus-1:0]     inst_addr;
        logic                  in_delayslot;
    } gpr_stage_t;

    typedef struct packed {
        logic [RegBus-1:0] hi;
        logic [RegBus-1:0] lo;
        logic              whilo;
    } hilo_stage_t;

    // the accumulate count only ever reaches 2; an out-of-range 3 restarts the sequence
    function automatic logic [1:0] clamp_cnt(input logic [1:0] c);
        return (c > CntMax) ? 2'b00 : c;
    endfunction

endpackage

// File: rtl/ex_mem_sub2.sv
// EX->MEM pipeline register for the second issue slot; HI/LO path only with EX_MEM_SUB2_HILO_EN.
// Latency: one cycle, registered outputs only.
// Stall: EX stalled with MEM running inserts a bubble; both stalled holds the stage.
module ex_mem_sub2
    import ex_mem_sub2_pkg::*;
#(
    parameter int STALL_W = StallBus,
    parameter int EX_BIT  = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_W-1:0]      stall,
    input  logic                    flush,
    input  logic [RegAddrBus-1:0]   ex_wd,
    input  logic                    ex_wreg,
    input  logic [RegBus-1:0]       ex_wdata,
    input  logic [RegBus-1:0]       ex_hi,
    input  logic [RegBus-1:0]       ex_lo,
    input  logic                    ex_whilo,
    input  logic [RegBus-1:0]       ex_excepttype,
    input  logic [RegBus-1:0]       ex_inst_addr,
    input  logic                    ex_in_delayslot,
    input  logic [DoubleRegBus-1:0] hilo_i,
    input  logic [1:0]              cnt_i,
    output logic [RegAddrBus-1:0]   mem_wd,
    output logic                    mem_wreg,
    output logic [RegBus-1:0]       mem_wdata,
    output logic [RegBus-1:0]       mem_hi,
    output logic [RegBus-1:0]       mem_lo,
    output logic                    mem_whilo,
    output logic [RegBus-1:0]       mem_excepttype,
    output logic [RegBus-1:0]       mem_inst_addr,
    output logic                    mem_in_delayslot,
    output logic                    mem_valid,
    output logic [DoubleRegBus-1:0] hilo_o,
    output logic [1:0]              cnt_o
);

    localparam int MEM_BIT = EX_BIT + 1;

    gpr_stage_t gpr_q;
    logic       valid_q;

`ifdef EX_MEM_SUB2_HILO_EN
    hilo_stage_t             hl_q;
    logic [DoubleRegBus-1:0] acc_q;
    logic [1:0]              cnt_q;
`endif

    always_ff @(posedge clk) begin
        if (rst == RstEnable || flush) begin
            gpr_q   <= '0;
            valid_q <= 1'b0;
`ifdef EX_MEM_SUB2_HILO_EN
            hl_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= 2'b00;
`endif
        end else if (stall[EX_BIT] && !stall[MEM_BIT]) begin
            // bubble: MEM sees nothing, but the partial accumulate loops back to EX
            gpr_q   <= '0;
            valid_q <= 1'b0;
`ifdef EX_MEM_SUB2_HILO_EN
            hl_q    <= '0;
            acc_q   <= hilo_i;
            cnt_q   <= clamp_cnt(cnt_i);
`endif
        end else if (!stall[EX_BIT]) begin
            // overflow (excepttype bit ExcOverflowBit) does not gate wreg here
            gpr_q.wd           <= ex_wd;
            gpr_q.wreg         <= ex_wreg;
            gpr_q.wdata        <= ex_wdata;
            gpr_q.excepttype   <= ex_excepttype;
            gpr_q.inst_addr    <= ex_inst_addr;
            gpr_q.in_delayslot <= ex_in_delayslot;
            valid_q            <= 1'b1;
`ifdef EX_MEM_SUB2_HILO_EN
            hl_q.hi            <= ex_hi;
            hl_q.lo            <= ex_lo;
            hl_q.whilo         <= ex_whilo;
            acc_q              <= '0;
            cnt_q              <= 2'b00;
`endif
        end
    end

    assign mem_wd           = gpr_q.wd;
    assign mem_wreg         = gpr_q.wreg;
    assign mem_wdata        = gpr_q.wdata;
    assign mem_excepttype   = gpr_q.excepttype;
    assign mem_inst_addr    = gpr_q.inst_addr;
    assign mem_in_delayslot = gpr_q.in_delayslot;
    assign mem_valid        = valid_q;

`ifdef EX_MEM_SUB2_HILO_EN
    assign mem_hi    = hl_q.hi;
    assign mem_lo    = hl_q.lo;
    assign mem_whilo = hl_q.whilo;
    assign hilo_o    = acc_q;
    assign cnt_o     = cnt_q;

    logic unused_in;
    assign unused_in = ^stall;
`else
    assign mem_hi    = ZeroWord;
    assign mem_lo    = ZeroWord;
    assign mem_whilo = WriteDisable;
    assign hilo_o    = '0;
    assign cnt_o     = 2'b00;

    logic unused_in;
    assign unused_in = ^{stall, ex_hi, ex_lo, ex_whilo, hilo_i, cnt_i};
`endif

endmodule

// File: doc/ex_mem_sub2.md
EX_MEM_SUB2 -- requirements
Module: ex_mem_sub2

Interface
REQ-001 SHALL have parameter STALL_W, default 6: width of the pipeline stall vector.
REQ-002 SHALL have parameter EX_BIT, default 3: stall-vector index of the EX stage; EX_BIT+1 is the MEM stage.
REQ-003 SHALL have port clk  in  1  pipeline clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high (RstEnable = 1).
REQ-005 SHALL have port stall  in  STALL_W  per-stage stall vector from the control unit.
REQ-006 SHALL have port flush  in  1  exception flush; clears the stage.
REQ-007 SHALL have ports ex_wd in 5, ex_wreg in 1, ex_wdata in 32: GPR write request from second-slot EX.
REQ-008 SHALL have ports ex_hi in 32, ex_lo in 32, ex_whilo in 1: HI/LO write request from second-slot EX.
REQ-009 SHALL have ports ex_excepttype in 32, ex_inst_addr in 32, ex_in_delayslot in 1: exception context.
REQ-010 SHALL have ports hilo_i in 64, cnt_i in 2: partial multi-cycle accumulate result and its cycle count from EX.
REQ-011 SHALL have outputs mem_wd 5, mem_wreg 1, mem_wdata 32, mem_hi 32, mem_lo 32, mem_whilo 1, mem_excepttype 32, mem_inst_addr 32, mem_in_delayslot 1: registered copies of the EX signals of REQ-007..009.
REQ-012 SHALL have output mem_valid 1: the stage holds a real instruction (not a bubble).
REQ-013 SHALL have outputs hilo_o 64 and cnt_o 2: accumulate state returned to EX.

Function
REQ-014 SHALL select one action per cycle, in priority order: RESET (rst=1), FLUSH (flush=1), BUBBLE (stall[EX_BIT]=1 and stall[EX_BIT+1]=0), LOAD (stall[EX_BIT]=0), HOLD (otherwise).
REQ-015 On RESET, all outputs SHALL become zero: mem_wreg=WriteDisable, mem_whilo=WriteDisable, mem_valid=0, hilo_o=0, cnt_o=0.
REQ-016 On FLUSH, every mem_* output and mem_valid SHALL be zeroed, and hilo_o and cnt_o SHALL also be zeroed.
REQ-017 On BUBBLE, every mem_* output and mem_valid SHALL be zeroed, while hilo_o<=hilo_i and cnt_o<=cnt_i.
REQ-018 On LOAD, every mem_* output SHALL take its ex_* input, mem_valid SHALL be 1, hilo_o SHALL become 0 and cnt_o SHALL become 0.
REQ-019 On HOLD, all outputs SHALL keep their previous values.
REQ-020 Latency SHALL be exactly one cycle from ex_* inputs to mem_* outputs on LOAD; there SHALL be no combinational path from input to output.
REQ-021 When ex_excepttype[12] (overflow) is set, the block SHALL forward ex_wreg unchanged; suppression of the write is done upstream.
REQ-022 When flush and stall are asserted in the same cycle, flush SHALL win.
REQ-023 cnt_o SHALL never exceed 2'b10; a cnt_i value of 2'b11 SHALL be captured as 2'b00.

Reset
REQ-024 Reset SHALL be sampled only on the rising edge of clk; there SHALL be no asynchronous reset path.
REQ-025 Reset asserted while an instruction is being held SHALL discard it within one cycle, and mem_valid SHALL be 0 on the following edge.

Configuration
REQ-026 With macro EX_MEM_SUB2_HILO_EN defined, the HI/LO path (mem_hi, mem_lo, mem_whilo, hilo_o, cnt_o) SHALL behave as REQ-014..023.
REQ-027 Without EX_MEM_SUB2_HILO_EN, those outputs SHALL be constant zero, their inputs SHALL be ignored, and no flops SHALL be inferred for them.

Structure
REQ-028 Stall-vector width, RstEnable, WriteEnable/WriteDisable, ZeroWord, RegBus/RegAddrBus/DoubleRegBus widths and the overflow bit index 12 SHALL come from the shared defines package.
REQ-029 The block SHALL be a single module with no sub-module; action decode and the data register SHALL sit in one clocked process.

Verification
REQ-030 The bench SHALL apply: rst=1 for 2 cycles with random inputs -> every output is 0 and mem_valid=0.
REQ-031 The bench SHALL apply: stall=0, ex_wd=5'd3, ex_wreg=1, ex_wdata=32'hDEADBEEF -> one cycle later mem_wd=3, mem_wdata=DEADBEEF, mem_valid=1.
REQ-032 The bench SHALL apply: stall=6'b001000, hilo_i=64'h1_0000_0002, cnt_i=1 -> mem_valid=0, mem_wreg=0, hilo_o=64'h1_0000_0002, cnt_o=1.
REQ-033 The bench SHALL apply: stall=6'b011000 for 3 cycles after a LOAD of wdata=32'h55 -> mem_wdata stays 32'h55 and mem_valid=1 throughout.
REQ-034 The bench SHALL apply: flush=1 with stall=6'b011000 -> all outputs 0 next cycle.
REQ-035 The bench SHALL build without EX_MEM_SUB2_HILO_EN and apply ex_whilo=1, ex_hi=32'hFFFF -> mem_whilo=0 and mem_hi=0, with GPR path unchanged.
